// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a header pattern, then collects a w-bit LSB-first word.
// Define SERIAL_FRAME_RX_PARITY_EN to add an even-parity bit after the data word.
module serial_frame_rx #(
    parameter int unsigned          w        = 8,
    parameter int unsigned          header_w = 4,
    parameter logic [header_w-1:0]  header   = 4'b1011
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         seq_in,
    output logic [w-1:0] data_out,
    output logic         data_valid,
    output logic         frame_err,
    output logic         busy,
    output logic [7:0]   frame_cnt
);
    localparam int unsigned IDX_W = (w > 1) ? $clog2(w) : 1;
    localparam int unsigned CNT_W = $clog2(header_w + 1);

    typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

    state_t              state_q, state_d;
    logic [header_w-1:0] hdr_sr_q, hdr_sr_d;
    logic [CNT_W-1:0]    hdr_cnt_q, hdr_cnt_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [w-1:0]        data_sr_q, data_sr_d;
    logic [w-1:0]        data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                busy_q, busy_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                frame_err_d;
    logic                complete;
    logic [w-1:0]        word;
    logic [header_w-1:0] win;
    logic [w-1:0]        data_nx;

    always_comb begin
        state_d      = state_q;
        hdr_sr_d     = hdr_sr_q;
        hdr_cnt_d    = hdr_cnt_q;
        bit_idx_d    = bit_idx_q;
        data_sr_d    = data_sr_q;
        data_out_d   = data_out_q;
        frame_cnt_d  = frame_cnt_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        complete     = 1'b0;
        word         = data_sr_q;
        win          = {hdr_sr_q[header_w-2:0], seq_in};
        data_nx      = {seq_in, data_sr_q[w-1:1]};

        if (en) begin
            case (state_q)
                HUNT: begin
                    hdr_sr_d = win;
                    if (hdr_cnt_q < CNT_W'(header_w)) hdr_cnt_d = hdr_cnt_q + CNT_W'(1);
                    // the count gate keeps reset zeros in the window from forming a match
                    if (win == header && hdr_cnt_d == CNT_W'(header_w)) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
                DATA: begin
                    data_sr_d = data_nx;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_W'(w - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_d = PARITY;
`else
                        complete = 1'b1;
                        word     = data_nx;
`endif
                    end
                end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                PARITY: begin
                    if (^{data_sr_q, seq_in} == 1'b0) begin
                        complete = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                        hdr_sr_d    = '0;
                        hdr_cnt_d   = '0;
                    end
                end
`endif
                default: state_d = HUNT;
            endcase
        end

        if (complete) begin
            data_out_d   = word;
            data_valid_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
            state_d      = HUNT;
            hdr_sr_d     = '0;
            hdr_cnt_d    = '0;
        end

        busy_d = (state_d != HUNT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            hdr_sr_q     <= '0;
            hdr_cnt_q    <= '0;
            bit_idx_q    <= '0;
            data_sr_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            hdr_sr_q     <= hdr_sr_d;
            hdr_cnt_q    <= hdr_cnt_d;
            bit_idx_q    <= bit_idx_d;
            data_sr_q    <= data_sr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic frame_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) frame_err_q <= 1'b0;
        else       frame_err_q <= frame_err_d;
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (w=8, header 1011); follows SERIAL_FRAME_RX_PARITY_EN.
module tb_serial_frame_rx;
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       seq_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic [7:0] frame_cnt;

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    serial_frame_rx #(.w(8), .header_w(4), .header(4'b1011)) dut (
        .clk(clk), .reset(reset), .en(en), .seq_in(seq_in),
        .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) valid_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One accepted bit, then `gap` idle en=0 cycles; returns #1 after the last edge.
    task automatic send_bit(input logic b, input int gap);
        en = 1'b1;
        seq_in = b;
        @(posedge clk); #1;
        en = 1'b0;
        seq_in = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input logic gaps);
        logic bits [0:12];
        int n;
        bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1; bits[3] = 1'b1;
        for (int i = 0; i < 8; i++) bits[4+i] = d[i];
        bits[12] = (^d) ^ flip;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        n = 13;
`else
        n = 12;
`endif
        for (int k = 0; k < n; k++) begin
            send_bit(bits[k], (gaps && k != n - 1) ? (k % 4) : 0);
            if (gaps && k == 7) check("gap_busy", {31'd0, busy}, 32'd1);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; seq_in = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cnt", {24'd0, frame_cnt}, 32'd0);
        reset = 1'b0;

        // idle junk without a header leaves outputs at reset values
        send_bit(1'b0, 0); send_bit(1'b0, 1); send_bit(1'b1, 0); send_bit(1'b0, 2);
        check("junk_data_out", {24'd0, data_out}, 32'h00);
        check("junk_cnt", {24'd0, frame_cnt}, 32'd0);

        // good frame A5
        send_frame(8'hA5, 1'b0, 1'b0);
        check("good_valid", {31'd0, data_valid}, 32'd1);
        check("good_data", {24'd0, data_out}, 32'hA5);
        check("good_cnt", {24'd0, frame_cnt}, 32'd1);
        check("good_err", {31'd0, frame_err}, 32'd0);
        check("good_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("good_valid_drop", {31'd0, data_valid}, 32'd0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_frame(8'hA5, 1'b1, 1'b0);
        check("bad_err", {31'd0, frame_err}, 32'd1);
        check("bad_valid", {31'd0, data_valid}, 32'd0);
        check("bad_data", {24'd0, data_out}, 32'hA5);
        check("bad_cnt", {24'd0, frame_cnt}, 32'd1);
        check("bad_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("bad_err_drop", {31'd0, frame_err}, 32'd0);
`endif

        // same frame with 0-3 idle cycles between accepted bits
        send_frame(8'hA5, 1'b0, 1'b1);
        check("gap_valid", {31'd0, data_valid}, 32'd1);
        check("gap_data", {24'd0, data_out}, 32'hA5);
        check("gap_cnt", {24'd0, frame_cnt}, 32'd2);

        // sliding header: 1,0,1,0,1,1 matches on the 6th bit
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
        send_bit(1'b0, 0); send_bit(1'b1, 0);
        check("slide_busy_pre", {31'd0, busy}, 32'd0);
        send_bit(1'b1, 0);
        check("slide_busy_match", {31'd0, busy}, 32'd1);
        begin
            logic [7:0] d;
            d = 8'h3C;
            for (int i = 0; i < 8; i++) send_bit(d[i], 0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
            send_bit(1'b0, 0);
`endif
        end
        check("slide_valid", {31'd0, data_valid}, 32'd1);
        check("slide_data", {24'd0, data_out}, 32'h3C);
        check("slide_cnt", {24'd0, frame_cnt}, 32'd3);

        // reset mid-frame after 3 data bits, en held high during reset
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        en = 1'b1; seq_in = 1'b1; reset = 1'b1;
        #1;
        check("mid_rst_data", {24'd0, data_out}, 32'h00);
        check("mid_rst_cnt", {24'd0, frame_cnt}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_valid", {31'd0, data_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; en = 1'b0; seq_in = 1'b0;
        send_frame(8'h81, 1'b0, 1'b0);
        check("post_rst_valid", {31'd0, data_valid}, 32'd1);
        check("post_rst_data", {24'd0, data_out}, 32'h81);
        check("post_rst_cnt", {24'd0, frame_cnt}, 32'd1);
        @(posedge clk); #1;

        check("valid_pulses", valid_cnt, 32'd4);
`ifdef SERIAL_FRAME_RX_PARITY_EN
        check("err_pulses", err_cnt, 32'd1);
`else
        check("err_pulses", err_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
